// File: rtl/lock_det_pkg.sv
// Shared defaults and types for the DPLL frequency-lock detector.
package lock_det_pkg;

  localparam int WINDOW       = 32;
  localparam int EXP_EDGES    = 8;
  localparam int TOL          = 1;
  localparam int LOCK_COUNT   = 4;
  localparam int UNLOCK_COUNT = 2;
  localparam int CNT_W        = 8;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/fb_edge_sync.sv
// Two-flop synchronizer for the feedback clock plus a rising-edge
// detector running in the clk_ref domain.
module fb_edge_sync (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic clk_fb,
  output logic rise
);

  logic s1;
  logic s2;
  logic p;

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      p  <= 1'b0;
    end else begin
      s1 <= clk_fb;
      s2 <= s1;
      p  <= s2;
    end
  end

  assign rise = s2 & ~p;

endmodule

// File: rtl/lock_detector.sv
// Frequency-lock detector: counts clk_fb edges per reference window and
// tracks runs of good/bad windows to drive a registered lock flag.
module lock_detector #(
  parameter int WINDOW       = lock_det_pkg::WINDOW,
  parameter int EXP_EDGES    = lock_det_pkg::EXP_EDGES,
  parameter int TOL          = lock_det_pkg::TOL,
  parameter int LOCK_COUNT   = lock_det_pkg::LOCK_COUNT,
  parameter int UNLOCK_COUNT = lock_det_pkg::UNLOCK_COUNT,
  parameter int CNT_W        = lock_det_pkg::CNT_W
) (
  input  logic clk_ref,
  input  logic rst_n,
  input  logic clk_fb,
  output logic lock
);

  import lock_det_pkg::*;

  localparam int WC_W = $clog2(WINDOW);
  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam int BC_W = $clog2(UNLOCK_COUNT + 1);
  localparam int LO   = (EXP_EDGES > TOL) ? EXP_EDGES - TOL : 0;
  localparam int HI   = EXP_EDGES + TOL;

  logic              rise;
  logic [WC_W-1:0]   wc;
  logic [CNT_W-1:0]  ec;
  logic [CNT_W:0]    total;
  logic              win_end;
  logic              good;
  logic [GC_W-1:0]   good_cnt;
  logic [GC_W-1:0]   good_nxt;
  logic [BC_W-1:0]   bad_cnt;
  logic [BC_W-1:0]   bad_nxt;
  lock_state_t       state;
  lock_state_t       state_nxt;

  fb_edge_sync u_sync (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .clk_fb  (clk_fb),
    .rise    (rise)
  );

  // A rise in the closing cycle still belongs to the closing window.
  assign win_end = (wc == WC_W'(WINDOW - 1));
  assign total   = {1'b0, ec} + {{CNT_W{1'b0}}, rise};
  assign good    = (total >= (CNT_W+1)'(LO)) &&
                   (total <= (CNT_W+1)'(HI));

  always_comb begin
    good_nxt = '0;
    bad_nxt  = '0;
    if (good) begin
      good_nxt = (good_cnt == GC_W'(LOCK_COUNT)) ?
                 good_cnt : good_cnt + 1'b1;
    end else begin
      bad_nxt = (bad_cnt == BC_W'(UNLOCK_COUNT)) ?
                bad_cnt : bad_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      wc       <= '0;
      ec       <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      wc <= win_end ? '0 : wc + 1'b1;
      if (win_end) begin
        ec       <= '0;
        good_cnt <= good_nxt;
        bad_cnt  <= bad_nxt;
      end else if (rise && (ec != '1)) begin
        ec <= ec + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      UNLOCKED: begin
        if (win_end && (good_nxt == GC_W'(LOCK_COUNT)))
          state_nxt = LOCKED;
      end
      LOCKED: begin
        if (win_end && (bad_nxt == BC_W'(UNLOCK_COUNT)))
          state_nxt = UNLOCKED;
      end
    endcase
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) state <= UNLOCKED;
    else        state <= state_nxt;
  end

  assign lock = (state == LOCKED);

endmodule

// File: tb/tb_lock_detector.sv
// Directed bench for lock_detector: divider and per-window edge-mask
// stimulus on clk_fb, lock checked on the falling edge of clk_ref.
module tb_lock_detector;

  logic clk_ref = 1'b0;
  logic rst_n;
  logic clk_fb;
  logic lock;

  int vectors     = 0;
  int miscompares = 0;

  int mode = 1;
  int div  = 4;
  int gc   = 0;
  int bwc  = 0;
  int bwin = 0;
  int ov1  = -1;
  int ov2  = -1;
  logic [31:0] mask_a = '0;
  logic [31:0] mask_b = '0;
  logic [31:0] mask_c = '0;
  logic [31:0] cur_mask;

  lock_detector dut (
    .clk_ref (clk_ref),
    .rst_n   (rst_n),
    .clk_fb  (clk_fb),
    .lock    (lock)
  );

  always #5 clk_ref = ~clk_ref;

  // Reference window position, aligned with the detector's window.
  always @(posedge clk_ref) begin
    gc <= gc + 1;
    if (!rst_n) begin
      bwc  <= 0;
      bwin <= 0;
    end else begin
      bwc <= (bwc == 31) ? 0 : bwc + 1;
      if (bwc == 31) bwin <= bwin + 1;
    end
  end

  initial begin
    clk_fb = 1'b0;
    forever begin
      @(posedge clk_ref);
      #1;
      if (mode == 0) begin
        clk_fb = 1'b0;
      end else if (mode == 1) begin
        clk_fb = ((gc % div) < (div / 2));
      end else begin
        if (bwin == ov1 || bwin == ov2) cur_mask = mask_c;
        else if ((bwin % 2) == 1)       cur_mask = mask_b;
        else                            cur_mask = mask_a;
        clk_fb = cur_mask[bwc];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  // n one-cycle pulses at cycles 0,3,6..; bnd adds one at cycle 29,
  // whose rise lands on the last cycle of the window.
  function automatic logic [31:0] mk(input int n, input bit bnd);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m[3*i] = 1'b1;
    if (bnd) m[29] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: t=%0t got %0h want %0h", tag, $time, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_ref);
    rst_n = 1'b0;
    repeat (n) begin
      @(negedge clk_ref);
      chk("rst_hold", {31'b0, lock}, 32'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic relock(input string tag, input bit exp_lock);
    for (int i = 1; i < 128; i++) begin
      @(negedge clk_ref);
      chk({tag, "_early"}, {31'b0, lock}, 32'd0);
    end
    @(negedge clk_ref);
    chk({tag, "_c128"}, {31'b0, lock}, {31'b0, exp_lock});
  endtask

  task automatic hold(input string tag, input int n, input bit exp_lock);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_ref);
      chk(tag, {31'b0, lock}, {31'b0, exp_lock});
    end
  endtask

  task automatic to_wc(input int v);
    int n;
    n = 0;
    while (bwc != v && n < 40) begin
      @(negedge clk_ref);
      n++;
    end
    if (bwc != v) chk("to_wc_timeout", bwc, v);
  endtask

  initial begin
    rst_n = 1'b0;

    // ref/4 through reset and after release
    mode = 1;
    div  = 4;
    do_reset(10);
    relock("t1", 1'b1);

    // clk_fb stops: one bad window keeps lock, the second drops it
    to_wc(0);
    mode = 0;
    to_wc(31);
    chk("t2_bad1_end", {31'b0, lock}, 32'd1);
    @(negedge clk_ref);
    chk("t2_after_bad1", {31'b0, lock}, 32'd1);
    to_wc(31);
    chk("t2_bad2_end", {31'b0, lock}, 32'd1);
    @(negedge clk_ref);
    chk("t2_after_bad2", {31'b0, lock}, 32'd0);

    // too slow, then too fast
    mode = 1;
    div  = 8;
    hold("t3_ref8", 20 * 32, 1'b0);
    div  = 2;
    hold("t3_ref2", 8 * 32, 1'b0);

    // tolerance edges: 7/9 lock, 6 and 10 do not
    mode   = 2;
    mask_a = mk(7, 1'b0);
    mask_b = mk(9, 1'b0);
    do_reset(2);
    relock("t4_7_9", 1'b1);

    mask_a = mk(6, 1'b0);
    mask_b = mask_a;
    do_reset(2);
    relock("t4_6", 1'b0);
    hold("t4_6_late", 4 * 32, 1'b0);

    mask_a = mk(10, 1'b0);
    mask_b = mask_a;
    do_reset(2);
    relock("t4_10", 1'b0);
    hold("t4_10_late", 4 * 32, 1'b0);

    // isolated 3-edge windows while locked
    mask_a = mk(8, 1'b0);
    mask_b = mask_a;
    mask_c = mk(3, 1'b0);
    do_reset(2);
    relock("t5", 1'b1);
    ov1 = 5;
    ov2 = 7;
    hold("t5_glitch", 192, 1'b1);
    ov1 = -1;
    ov2 = -1;

    // one-cycle reset while locked, relock with a boundary edge
    mask_a = mk(7, 1'b1);
    mask_b = mask_a;
    do_reset(1);
    relock("t6_bnd8", 1'b1);

    mask_a = mk(6, 1'b1);
    mask_b = mask_a;
    do_reset(2);
    relock("t6_bnd7", 1'b1);
    hold("t6_bnd7_hold", 64, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lock_detector.md
Name: lock_detector

Overview:
- Frequency-lock detector for the DPLL: counts rising edges of the feedback clock clk_fb inside a fixed window of reference-clock cycles.
- Compares each window's count against an expected count with a tolerance.
- Asserts lock after enough consecutive good windows; drops it after enough consecutive bad windows.
- Single clock domain (clk_ref). clk_fb is treated as an asynchronous data input and is synchronized internally.

Parameters:
- WINDOW, 32, reference cycles per measurement window (>= 4).
- EXP_EDGES, 8, expected clk_fb rising edges per window (default ratio fb = ref/4).
- TOL, 1, allowed absolute deviation of the edge count from EXP_EDGES.
- LOCK_COUNT, 4, consecutive good windows required to assert lock.
- UNLOCK_COUNT, 2, consecutive bad windows required to deassert lock.
- CNT_W, 8, edge counter width; requires EXP_EDGES+TOL < 2^CNT_W.

Ports:
- clk_ref  in  1  reference clock; the single clock of the block, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- clk_fb  in  1  feedback clock, asynchronous to clk_ref; frequency must be <= clk_ref/2.
- lock  out  1  registered lock indication.

Behaviour:
- Clocking and reset: one clock, clk_ref. Reset is synchronous and active-low (rst_n).
- Reset clears all state: synchronizer flops, previous-sample flop, window counter, edge counter, good/bad run counters, and lock=0.
- Reset asserted mid-operation: lock=0 on the next clk_ref edge. The window restarts from cycle 0 after release.
- Synchronizer: clk_fb passes through 2 flops (s1, s2) and a previous-value flop p.
  - rise = s2 & ~p.
  - Edge-to-rise latency is 2-3 clk_ref cycles.
- Window counter wc: counts 0..WINDOW-1, then wraps to 0.
  - Window end is the cycle with wc==WINDOW-1.
- Edge counter ec: increments on rise and saturates at 2^CNT_W-1.
  - At window end, total = ec + rise. A rise in the final cycle belongs to the closing window.
  - ec is then loaded with 0 for the next window; no edge is lost or double-counted at the boundary.
- Window classification, at window end only:
  - good = (total >= EXP_EDGES-TOL) && (total <= EXP_EDGES+TOL). Compute unsigned, clamping the lower bound at 0.
  - A stuck clk_fb (total 0) is bad.
- Run counters, saturating:
  - Good window: good_cnt++ (saturates at LOCK_COUNT), bad_cnt=0.
  - Bad window: bad_cnt++ (saturates at UNLOCK_COUNT), good_cnt=0.
- Lock state, two states UNLOCKED and LOCKED:
  - UNLOCKED->LOCKED when the updated good_cnt reaches LOCK_COUNT. lock rises on the same clk_ref edge that registers the closing window's evaluation.
  - LOCKED->UNLOCKED when the updated bad_cnt reaches UNLOCK_COUNT.
  - A single bad window shorter than UNLOCK_COUNT leaves lock high.
  - Between window ends, lock is stable.
- Minimum lock latency after reset release: LOCK_COUNT*WINDOW cycles (128 at defaults). lock is never asserted earlier.
- clk_fb above clk_ref/2 aliases. Its count is undefined but must never set lock spuriously beyond what the counted total dictates. No special handling is required.

Decomposition:
- Shared package lock_det_pkg:
  - Default constants: WINDOW, EXP_EDGES, TOL, LOCK_COUNT, UNLOCK_COUNT, CNT_W.
  - Enum typedef lock_state_t {UNLOCKED, LOCKED}.
- One sub-module: fb_edge_sync (2-flop synchronizer + rising-edge detector). Ports: clk_ref, rst_n, clk_fb in; rise out.
- The top level holds the counters, classification and lock FSM.

Test Plan:
- Reset held 10 cycles with clk_fb toggling at ref/4 -> lock=0 throughout. After release, lock=0 for the first 128 cycles, then 1 within 132 cycles.
- Locked at ref/4, then clk_fb held at 0 -> lock stays 1 through the first bad window end, falls to 0 at the second bad window end (<= 64+4 cycles after the stop).
- clk_fb at ref/8 (4 edges/window) for 20 windows -> lock never asserts. At ref/2 (16 edges/window) -> lock never asserts.
- Tolerance boundary, pattern generator giving exactly 7 and then 9 edges/window -> locks after 4 windows. Exactly 6 or 10 edges/window -> never locks.
- Locked, then one window with 3 edges followed by ref/4 again -> lock remains 1 continuously; bad_cnt back to 0.
- Locked, rst_n pulsed low 1 cycle -> lock=0 on the next edge. Re-lock takes a full 128 cycles; an edge landing on wc==31 is counted in that window (verify 8-edge window with last edge at the boundary stays good).
